icache_ctrl: RTL and testbench

Blocking instruction-cache controller sitting between the CPU fetch port and the memory read port. Holds NUM_WAY instances of the existing valid/tag/data way block, performs lookup, selects a victim by per-set tree pseudo-LRU, refills a 256-bit line as eight 32-bit memory beats, and returns one 32-bit word per request. Read-only; no write-back path.

---
 rtl/icache_ctrl_pkg.sv | 52 +++++
 rtl/icache_plru.sv | 35 +++
 rtl/icache_way.sv | 46 ++++
 rtl/icache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_icache_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction-cache controller: field widths,
// address bit positions, FSM state encoding and tree-PLRU helpers.
// No ports; imported by icache_way, icache_plru and icache_ctrl.
package icache_ctrl_pkg;

    localparam int NUM_WAY        = 4;
    localparam int TAG_WIDTH      = 24;
    localparam int INDEX_WIDTH    = 3;
    localparam int LINE_WIDTH     = 256;
    localparam int WORD_WIDTH     = 32;
    localparam int WSEL_WIDTH     = 3;
    localparam int OFFSET_WIDTH   = 5;
    localparam int NUM_SET        = 1 << INDEX_WIDTH;
    localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
    localparam int WSEL_LSB       = 2;
    localparam int INDEX_LSB      = OFFSET_WIDTH;
    localparam int TAG_LSB        = OFFSET_WIDTH + INDEX_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MEM_REQ = 3'd2,
        ST_REFILL  = 3'd3,
        ST_FILL    = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    // PLRU bits: [0] root (0 = ways 0/1), [1] picks within 0/1, [2] within 2/3.
    function automatic logic [1:0] plru_victim(input logic [2:0] bits);
        logic [1:0] way;
        case (bits[0])
            1'b0:    way = bits[1] ? 2'd1 : 2'd0;
            default: way = bits[2] ? 2'd3 : 2'd2;
        endcase
        return way;
    endfunction

    // Point every node on the accessed way's path away from that way.
    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] nxt;
        nxt = bits;
        case (way)
            2'd0:    begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
            2'd1:    begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
            2'd2:    begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
            2'd3:    begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
            default: nxt = bits;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set 3-bit tree pseudo-LRU state with victim selection.
// Ports: clk_i/rst_i (sync, active-high, clears all bits), index_i set,
// valid_i way valid bits at that set, upd_i/upd_way_i touch strobe and way,
// victim_o lowest invalid way, else the PLRU victim.
module icache_plru
    import icache_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [INDEX_WIDTH-1:0] index_i,
    input  logic [NUM_WAY-1:0]     valid_i,
    input  logic                   upd_i,
    input  logic [1:0]             upd_way_i,
    output logic [1:0]             victim_o
);

    logic [2:0] plru_q [NUM_SET];

    // PLRU bit storage, touched on hit and on fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NUM_SET; s++) begin
                plru_q[s] <= 3'd0;
            end
        end else if (upd_i) begin
            plru_q[index_i] <= plru_touch(plru_q[index_i], upd_way_i);
        end
    end

    assign victim_o = !valid_i[0] ? 2'd0 :
                      !valid_i[1] ? 2'd1 :
                      !valid_i[2] ? 2'd2 :
                      !valid_i[3] ? 2'd3 : plru_victim(plru_q[index_i]);

endmodule

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and 256-bit line.
// Ports: clk_i/rst_i (sync, active-high, clears valid bits only),
// raddr_i -> rvalid_o/rtag_o/rdata_o (combinational read),
// wen_i/waddr_i/wvalid_i/wtag_i/wdata_i (synchronous write).
module icache_way
    import icache_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [INDEX_WIDTH-1:0] raddr_i,
    output logic                   rvalid_o,
    output logic [TAG_WIDTH-1:0]   rtag_o,
    output logic [LINE_WIDTH-1:0]  rdata_o,
    input  logic                   wen_i,
    input  logic [INDEX_WIDTH-1:0] waddr_i,
    input  logic                   wvalid_i,
    input  logic [TAG_WIDTH-1:0]   wtag_i,
    input  logic [LINE_WIDTH-1:0]  wdata_i
);

    logic [NUM_SET-1:0]    valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [NUM_SET];
    logic [LINE_WIDTH-1:0] data_q [NUM_SET];

    // Valid bits: cleared on reset, written on fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= {NUM_SET{1'b0}};
        end else if (wen_i) begin
            valid_q[waddr_i] <= wvalid_i;
        end
    end

    // Tag and data storage; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clk_i) begin
        if (wen_i) begin
            tag_q[waddr_i]  <= wtag_i;
            data_q[waddr_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[raddr_i];
    assign rtag_o   = tag_q[raddr_i];
    assign rdata_o  = data_q[raddr_i];

endmodule

// File: rtl/icache_ctrl.sv
// Blocking read-only instruction-cache controller.
// CPU side: from_cpu_inst_req_valid/addr, to_cpu_inst_req_ready,
// to_cpu_cache_rsp_valid/data, from_cpu_cache_rsp_ready.
// Memory side: to_mem_rd_req_valid/addr, from_mem_rd_req_ready,
// from_mem_rd_rsp_valid/data/last, to_mem_rd_rsp_ready.
// clk single clock, rst synchronous active-high; all outputs 0 while rst is high.
module icache_ctrl
    import icache_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cpu_inst_req_valid,
    input  logic [31:0] from_cpu_inst_req_addr,
    output logic        to_cpu_inst_req_ready,
    output logic        to_cpu_cache_rsp_valid,
    output logic [31:0] to_cpu_cache_rsp_data,
    input  logic        from_cpu_cache_rsp_ready,
    output logic        to_mem_rd_req_valid,
    output logic [31:0] to_mem_rd_req_addr,
    input  logic        from_mem_rd_req_ready,
    input  logic        from_mem_rd_rsp_valid,
    input  logic [31:0] from_mem_rd_rsp_data,
    input  logic        from_mem_rd_rsp_last,
    output logic        to_mem_rd_rsp_ready
);

    state_e                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [WSEL_WIDTH-1:0]  wsel_q;
    logic [WSEL_WIDTH-1:0]  beat_cnt_q;
    logic [WORD_WIDTH-1:0]  rsp_data_q;
    logic [WORD_WIDTH-1:0]  buf_q [WORDS_PER_LINE];

    logic [NUM_WAY-1:0]     rvalid_s, hit_vec_s, wen_s;
    logic [TAG_WIDTH-1:0]   rtag_s  [NUM_WAY];
    logic [LINE_WIDTH-1:0]  rdata_s [NUM_WAY];
    logic [LINE_WIDTH-1:0]  fill_line_s, hit_line_s;
    logic [WORD_WIDTH-1:0]  hit_word_s;
    logic                   hit_s, fill_s, plru_upd_s;
    logic [1:0]             hit_way_s, victim_s, plru_way_s;
    logic                   unused_addr_s;

    assign unused_addr_s = ^from_cpu_inst_req_addr[1:0];

    for (genvar w = 0; w < NUM_WAY; w++) begin : g_way
        icache_way u_way (
            .clk_i    (clk),
            .rst_i    (rst),
            .raddr_i  (idx_q),
            .rvalid_o (rvalid_s[w]),
            .rtag_o   (rtag_s[w]),
            .rdata_o  (rdata_s[w]),
            .wen_i    (wen_s[w]),
            .waddr_i  (idx_q),
            .wvalid_i (1'b1),
            .wtag_i   (tag_q),
            .wdata_i  (fill_line_s)
        );
        assign hit_vec_s[w] = rvalid_s[w] && (rtag_s[w] == tag_q);
        assign wen_s[w]     = fill_s && (victim_s == 2'(w));
    end

    // Beat 0 lands in the lowest word of the line.
    for (genvar b = 0; b < WORDS_PER_LINE; b++) begin : g_line
        assign fill_line_s[b*WORD_WIDTH +: WORD_WIDTH] = buf_q[b];
    end

    assign hit_s      = |hit_vec_s;
    assign hit_way_s  = hit_vec_s[0] ? 2'd0 : hit_vec_s[1] ? 2'd1 : hit_vec_s[2] ? 2'd2 : 2'd3;
    assign hit_line_s = rdata_s[hit_way_s];
    assign hit_word_s = hit_line_s[{wsel_q, 5'd0} +: WORD_WIDTH];
    assign plru_way_s = fill_s ? victim_s : hit_way_s;

    icache_plru u_plru (
        .clk_i     (clk),
        .rst_i     (rst),
        .index_i   (idx_q),
        .valid_i   (rvalid_s),
        .upd_i     (plru_upd_s),
        .upd_way_i (plru_way_s),
        .victim_o  (victim_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = from_cpu_inst_req_valid ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP:  state_d = hit_s ? ST_RESP : ST_MEM_REQ;
            ST_MEM_REQ: state_d = from_mem_rd_req_ready ? ST_REFILL : ST_MEM_REQ;
            ST_REFILL:  state_d = (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) ? ST_FILL : ST_REFILL;
            ST_FILL:    state_d = ST_LOOKUP;
            ST_RESP:    state_d = from_cpu_cache_rsp_ready ? ST_IDLE : ST_RESP;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; everything is forced low while rst is high.
    always_comb begin
        to_cpu_inst_req_ready  = 1'b0;
        to_cpu_cache_rsp_valid = 1'b0;
        to_mem_rd_req_valid    = 1'b0;
        to_mem_rd_rsp_ready    = 1'b0;
        fill_s                 = 1'b0;
        plru_upd_s             = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE:    to_cpu_inst_req_ready  = 1'b1;
                ST_LOOKUP:  plru_upd_s             = hit_s;
                ST_MEM_REQ: to_mem_rd_req_valid    = 1'b1;
                ST_REFILL:  to_mem_rd_rsp_ready    = 1'b1;
                ST_FILL:    begin fill_s = 1'b1; plru_upd_s = 1'b1; end
                ST_RESP:    to_cpu_cache_rsp_valid = 1'b1;
                default:    to_cpu_inst_req_ready  = 1'b0;
            endcase
        end else begin
            fill_s = 1'b0;
        end
    end

    assign to_cpu_cache_rsp_data = rst ? 32'd0 : rsp_data_q;
    assign to_mem_rd_req_addr    = rst ? 32'd0 : {tag_q, idx_q, 5'd0};

    // Request address latch, response word capture and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= {TAG_WIDTH{1'b0}};
            idx_q      <= {INDEX_WIDTH{1'b0}};
            wsel_q     <= {WSEL_WIDTH{1'b0}};
            beat_cnt_q <= {WSEL_WIDTH{1'b0}};
            rsp_data_q <= {WORD_WIDTH{1'b0}};
        end else begin
            if (state_q == ST_IDLE && from_cpu_inst_req_valid) begin
                tag_q  <= from_cpu_inst_req_addr[31:TAG_LSB];
                idx_q  <= from_cpu_inst_req_addr[TAG_LSB-1:INDEX_LSB];
                wsel_q <= from_cpu_inst_req_addr[INDEX_LSB-1:WSEL_LSB];
            end
            if (state_q == ST_LOOKUP && hit_s) begin
                rsp_data_q <= hit_word_s;
            end
            // Wraps back to 0 after the eighth beat, ready for the next refill.
            if (state_q == ST_REFILL && from_mem_rd_rsp_valid) begin
                beat_cnt_q <= beat_cnt_q + 3'd1;
            end
        end
    end

    // Refill line buffer; only read in FILL, so a partial line left by reset is harmless.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_REFILL && from_mem_rd_rsp_valid) begin
            buf_q[beat_cnt_q] <= from_mem_rd_rsp_data;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        from_cpu_inst_req_valid;
    logic [31:0] from_cpu_inst_req_addr;
    logic        to_cpu_inst_req_ready;
    logic        to_cpu_cache_rsp_valid;
    logic [31:0] to_cpu_cache_rsp_data;
    logic        from_cpu_cache_rsp_ready;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready;
    logic        from_mem_rd_rsp_valid;
    logic [31:0] from_mem_rd_rsp_data;
    logic        from_mem_rd_rsp_last;
    logic        to_mem_rd_rsp_ready;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk                      (clk),
        .rst                      (rst),
        .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
        .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
        .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
        .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
        .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
        .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
        .to_mem_rd_req_valid      (to_mem_rd_req_valid),
        .to_mem_rd_req_addr       (to_mem_rd_req_addr),
        .from_mem_rd_req_ready    (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected word and latency pushed at request time.
    logic [31:0] exp_data_q [$];
    int          exp_lat_q  [$];

    // Reference cache model.
    bit          m_valid [8][4];
    logic [23:0] m_tag   [8][4];
    logic [2:0]  m_plru  [8];

    // Memory model state.
    bit          mem_active = 1'b0;
    bit          mem_gaps   = 1'b0;
    logic [31:0] mem_line   = 32'd0;
    int          mem_beat   = 0;
    int          mem_req_cnt = 0;
    int          mem_beats_acc = 0;
    logic [31:0] mem_last_req = 32'd0;
    bit          prev_req_valid = 1'b0;
    bit          prev_rsp_ready = 1'b0;
    logic [31:0] prev_req_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
        return line - 32'h0000_0020 + 32'(i);
    endfunction

    function automatic int m_victim(input logic [2:0] b);
        if (b[0]) return b[2] ? 3 : 2;
        else      return b[1] ? 1 : 0;
    endfunction

    function automatic logic [2:0] m_touch(input logic [2:0] b, input int v);
        logic [2:0] r;
        r = b;
        r[0] = (v < 2);
        if (v < 2) r[1] = (v == 0);
        else       r[2] = (v == 2);
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_plru[s] = 3'd0;
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = 24'd0;
            end
        end
        exp_data_q.delete();
        exp_lat_q.delete();
    endtask

    task automatic model_access(input logic [31:0] addr, output bit hit);
        int s; int v; logic [23:0] t;
        s = int'(addr[7:5]);
        t = addr[31:8];
        hit = 1'b0;
        v = -1;
        for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; v = w; end
        if (!hit) begin
            for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) v = m_victim(m_plru[s]);
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = t;
        end
        m_plru[s] = m_touch(m_plru[s], v);
    endtask

    // Memory responder: all decisions at negedge, one beat per cycle when no gaps.
    initial begin
        from_mem_rd_req_ready = 1'b1;
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_data  = 32'd0;
        from_mem_rd_rsp_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_active = 1'b0;
            end else begin
                if (from_mem_rd_rsp_valid && prev_rsp_ready) begin
                    mem_beats_acc++;
                    mem_beat++;
                    if (mem_beat == 8) mem_active = 1'b0;
                end
                if (prev_req_valid && from_mem_rd_req_ready) begin
                    mem_active   = 1'b1;
                    mem_line     = prev_req_addr;
                    mem_beat     = 0;
                    mem_req_cnt++;
                    mem_last_req = prev_req_addr;
                end
            end
            if (mem_active && (!mem_gaps || $urandom_range(0, 1) == 1)) begin
                from_mem_rd_rsp_valid = 1'b1;
                from_mem_rd_rsp_data  = mem_word(mem_line, mem_beat);
                from_mem_rd_rsp_last  = (mem_beat == 7);
            end else begin
                from_mem_rd_rsp_valid = 1'b0;
                from_mem_rd_rsp_data  = 32'hDEAD_BEEF;
                from_mem_rd_rsp_last  = 1'b0;
            end
            prev_req_valid = to_mem_rd_req_valid;
            prev_rsp_ready = to_mem_rd_rsp_ready;
            prev_req_addr  = to_mem_rd_req_addr;
        end
    end

    // One complete fetch: push expectation, handshake, wait for the response, compare.
    task automatic fetch(input logic [31:0] addr, input bit stall, input bit chk_lat);
        bit hit; int lat; int req0; int s; logic [31:0] held; logic [31:0] exp_d; int exp_l;
        model_access(addr, hit);
        exp_data_q.push_back(mem_word({addr[31:5], 5'd0}, int'(addr[4:2])));
        exp_lat_q.push_back(chk_lat ? (hit ? 2 : 13) : -1);
        req0 = mem_req_cnt;
        s = int'(addr[7:5]);
        @(negedge clk);
        from_cpu_inst_req_valid  = 1'b1;
        from_cpu_inst_req_addr   = addr;
        from_cpu_cache_rsp_ready = !stall;
        lat = 0;
        while (!to_cpu_inst_req_ready && lat < 50) begin @(negedge clk); lat++; end
        checks++;
        if (!to_cpu_inst_req_ready) begin errors++; $display("FAIL req_ready_timeout addr=%h got 0 expected 1", addr); end
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) from_cpu_inst_req_valid = 1'b0;
            lat++;
        end while (!to_cpu_cache_rsp_valid && lat < 300);
        checks++;
        if (!to_cpu_cache_rsp_valid) begin errors++; $display("FAIL rsp_timeout addr=%h got 0 expected 1", addr); end
        if (stall) begin
            held = to_cpu_cache_rsp_data;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checks++;
                if (to_cpu_cache_rsp_valid !== 1'b1 || to_cpu_cache_rsp_data !== held || to_cpu_inst_req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got valid=%b data=%h ready=%b expected 1 %h 0",
                             i, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data, to_cpu_inst_req_ready, held);
                end
            end
            from_cpu_cache_rsp_ready = 1'b1;
        end
        // Response handshakes at the coming posedge.
        exp_d = exp_data_q.pop_front();
        exp_l = exp_lat_q.pop_front();
        checks++;
        if (to_cpu_cache_rsp_data !== exp_d) begin
            errors++; $display("FAIL rsp_data addr=%h got %h expected %h", addr, to_cpu_cache_rsp_data, exp_d);
        end
        if (exp_l >= 0) begin
            checks++;
            if (lat != exp_l) begin errors++; $display("FAIL latency addr=%h got %0d expected %0d", addr, lat, exp_l); end
        end
        checks++;
        if (mem_req_cnt - req0 != (hit ? 0 : 1)) begin
            errors++; $display("FAIL mem_req_count addr=%h got %0d expected %0d", addr, mem_req_cnt - req0, hit ? 0 : 1);
        end
        if (!hit) begin
            checks++;
            if (mem_last_req !== {addr[31:5], 5'd0}) begin
                errors++; $display("FAIL mem_req_addr got %h expected %h", mem_last_req, {addr[31:5], 5'd0});
            end
        end
        checks++;
        if (dut.u_plru.plru_q[s] !== m_plru[s]) begin
            errors++; $display("FAIL plru_bits set=%0d got %b expected %b", s, dut.u_plru.plru_q[s], m_plru[s]);
        end
        @(negedge clk);
        from_cpu_cache_rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        from_cpu_inst_req_valid  = 1'b0;
        from_cpu_inst_req_addr   = 32'd0;
        from_cpu_cache_rsp_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready} !== 4'b0000
            || to_cpu_cache_rsp_data !== 32'd0 || to_mem_rd_req_addr !== 32'd0) begin
            errors++; $display("FAIL reset_outputs got ready=%b rv=%b mv=%b mr=%b expected all 0",
                               to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (to_cpu_inst_req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b expected 1", to_cpu_inst_req_ready); end
    endtask

    task automatic test_cold_miss_and_hit();
        fetch(32'h0000_1024, 1'b0, 1'b1);
        fetch(32'h0000_1024, 1'b0, 1'b1);
        fetch(32'h0000_103C, 1'b0, 1'b1);
    endtask

    task automatic test_plru_evict();
        for (int t = 2; t <= 5; t++) fetch({24'(t * 16), 3'd1, 5'd4}, 1'b0, 1'b1);
        fetch(32'h0000_1024, 1'b0, 1'b1);
    endtask

    task automatic test_hit_between_fills();
        for (int t = 0; t < 4; t++) fetch({24'(256 + t), 3'd2, 5'd0}, 1'b0, 1'b1);
        fetch({24'd256, 3'd2, 5'd8}, 1'b0, 1'b1);
        fetch({24'd260, 3'd2, 5'd28}, 1'b0, 1'b1);
        for (int t = 0; t < 4; t++) fetch({24'(256 + t), 3'd2, 5'd16}, 1'b0, 1'b1);
    endtask

    task automatic test_rsp_stall();
        fetch(32'h0000_2048, 1'b1, 1'b1);
        fetch(32'h0000_2048, 1'b1, 1'b1);
    endtask

    task automatic test_mem_gaps();
        mem_gaps = 1'b1;
        fetch(32'h0000_40A4, 1'b0, 1'b0);
        fetch(32'h0000_50B8, 1'b0, 1'b0);
        mem_gaps = 1'b0;
        fetch(32'h0000_40A4, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            fetch({24'(12'h600 + $urandom_range(0, 5)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00},
                  1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid_refill();
        int start; int n;
        @(negedge clk);
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = 32'h0000_30E8;
        start = mem_beats_acc;
        @(negedge clk);
        from_cpu_inst_req_valid = 1'b0;
        n = 0;
        while (mem_beats_acc < start + 4 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (mem_beats_acc < start + 4) begin errors++; $display("FAIL refill_beats got %0d expected 4", mem_beats_acc - start); end
        rst = 1'b1;
        #1;
        checks++;
        if (to_mem_rd_rsp_ready !== 1'b0 || to_cpu_inst_req_ready !== 1'b0) begin
            errors++; $display("FAIL outputs_in_reset got rsp_ready=%b req_ready=%b expected 0 0", to_mem_rd_rsp_ready, to_cpu_inst_req_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (to_cpu_inst_req_ready !== 1'b1 || to_mem_rd_rsp_ready !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got req_ready=%b rsp_ready=%b expected 1 0", to_cpu_inst_req_ready, to_mem_rd_rsp_ready);
        end
        fetch(32'h0000_1024, 1'b0, 1'b1);
        fetch(32'h0000_2048, 1'b0, 1'b1);
        fetch(32'h0000_30E8, 1'b0, 1'b1);
        fetch(32'h0000_30E8, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_plru_evict();
        test_hit_between_fills();
        test_rsp_stall();
        test_mem_gaps();
        test_back_to_back();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
